tl_monitor: RTL and testbench
=============================

Name: tl_monitor

Overview:
- Passive checker on the six lamp outputs of the intersection controller: NS_R/NS_Y/NS_G and EW_R/EW_Y/EW_G.
- Decodes the lamps into a phase, measures how long each phase lasts, and checks phase order and dwell time against the configured timing.
- Reports per-event error pulses, sticky error flags and a count of completed rotations; used in system sim and as an on-chip safety watchdog.

Parameters:
- GREEN_CYCLES, 6, required dwell in clock cycles of NS_GREEN and EW_GREEN.
- YELLOW_CYCLES, 3, required dwell in clock cycles of NS_YELLOW and EW_YELLOW.
- DWELL_W, 8, width of the dwell counter; the counter saturates at all-ones.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ns_r, ns_y, ns_g  input  1 each  observed north-south lamps.
- ew_r, ew_y, ew_g  input  1 each  observed east-west lamps.
- clr_err  input  1  synchronous clear of err_flags.
- phase  output  2  decoded phase: 00 NS_GREEN, 01 NS_YELLOW, 10 EW_GREEN, 11 EW_YELLOW.
- phase_valid  output  1  phase holds a legal decoded pattern.
- err_pat  output  1  1-cycle pulse: illegal lamp pattern.
- err_seq  output  1  1-cycle pulse: illegal phase successor.
- err_dur  output  1  1-cycle pulse: completed phase had the wrong dwell.
- err_flags  output  3  sticky flags {dur, seq, pat}.
- rotations  output  8  count of legal EW_YELLOW->NS_GREEN transitions; wraps 255->0.

Behaviour:
- Reset (rst_n low, asynchronous): phase=00, phase_valid=0, all err_* outputs=0, err_flags=000, rotations=0, dwell=0, FSM in SYNC, input sample register=0.
- Stage 1: the six lamps are registered every cycle.
- Stage 2: the registered lamps are decoded combinationally, and all outputs are registered from that decode.
- Latency: a lamp change presented before edge k is reflected on phase/err_* after edge k+1.
- Legal patterns, and only these (everything else is illegal, including all-off, both-red, both-green, multiple lamps lit on one road):
  - NS_G+EW_R = 00
  - NS_Y+EW_R = 01
  - EW_G+NS_R = 10
  - EW_Y+NS_R = 11
- Required successors: 00->01->10->11->00.
- FSM states:
  - SYNC: waiting for the first legal pattern. phase_valid=0. A legal pattern goes to TRACK, sets dwell=1 and sets the first_phase flag.
  - TRACK, same phase as last cycle: dwell increments, saturating at 2^DWELL_W-1.
  - TRACK, phase changes: the new phase is checked against the required successor; a mismatch pulses err_seq.
  - TRACK, phase changes, dwell check: the ended phase's dwell is compared with GREEN_CYCLES (phase 00/10) or YELLOW_CYCLES (01/11); a mismatch pulses err_dur. The check is skipped when first_phase is set, because the first phase after sync is partial. first_phase then clears, and dwell restarts at 1.
  - TRACK, illegal pattern: pulse err_pat, go to SYNC, phase_valid=0, and phase holds its last value.
- Multiple errors:
  - In SYNC, err_pat pulses on every illegal cycle.
  - err_seq and err_dur may pulse in the same cycle.
- rotations increments only on an 11->00 transition that passes the successor check, whether or not the dwell check passes.
- err_flags:
  - Each bit is set by its pulse.
  - clr_err clears all bits on the next edge.
  - If a pulse and clr_err occur in the same cycle, the pulse's bit ends set.
- Dwell saturation: a stuck phase never wraps. Its eventual change reports err_dur.
- rst_n asserted mid-phase: immediate return to the reset values. Checking after reset starts from SYNC with the first-phase exemption.

Optional Feature:
- Macro: TLM_FAULT_LATCH_EN.
- Defined:
  - Any err_* pulse moves the FSM to a FAULT state and asserts an extra output port, fault (1 bit).
  - In FAULT, phase_valid=0, and no further pulses, dwell updates or rotation counts occur.
  - Exit from FAULT is by rst_n only; clr_err clears err_flags but not FAULT.
- Undefined: no fault port and no FAULT state; behaviour is as above.

Test Plan:
- Reset, then a legal rotation 00 for 6 cycles, 01 for 3, 10 for 6, 11 for 3, 00 -> no error pulses; rotations=1; phase_valid high from the 2nd cycle after the first legal pattern.
- First phase after reset lasts 1 cycle, then a legal sequence follows -> no err_dur for that first phase; the following phases are checked normally.
- NS_GREEN held for 7 cycles, then NS_YELLOW -> one err_dur pulse; err_flags=100; no err_seq.
- Sequence 00 then 10 with correct dwell -> err_seq pulse; err_flags=010; then 10->11->00 -> rotations increments.
- NS_G and EW_G both high for 2 cycles mid-phase -> err_pat pulses for 2 cycles; FSM in SYNC; the next legal phase is exempt from the dwell check. Then clr_err the same cycle as a new err_pat -> err_flags[0] stays 1.
- With TLM_FAULT_LATCH_EN: one err_dur -> fault=1 and rotations frozen across 3 further rotations; clr_err leaves fault=1; rst_n low -> fault=0.

Source files
------------

// File: rtl/tl_monitor.sv
// Passive checker for the intersection lamp outputs: decodes phase, checks order and dwell, counts rotations.
// Latency: lamp change before edge k is visible on outputs after edge k+1; never backpressures. Option: TLM_FAULT_LATCH_EN.
module tl_monitor #(
  parameter int GREEN_CYCLES  = 6,
  parameter int YELLOW_CYCLES = 3,
  parameter int DWELL_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ns_r,
  input  logic       ns_y,
  input  logic       ns_g,
  input  logic       ew_r,
  input  logic       ew_y,
  input  logic       ew_g,
  input  logic       clr_err,
  output logic [1:0] phase,
  output logic       phase_valid,
  output logic       err_pat,
  output logic       err_seq,
  output logic       err_dur,
  output logic [2:0] err_flags,
`ifdef TLM_FAULT_LATCH_EN
  output logic       fault,
`endif
  output logic [7:0] rotations
);

  localparam logic [DWELL_W-1:0] GREEN_DW  = DWELL_W'(GREEN_CYCLES);
  localparam logic [DWELL_W-1:0] YELLOW_DW = DWELL_W'(YELLOW_CYCLES);
  localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

  typedef enum logic [1:0] {
    S_SYNC  = 2'd0,
    S_TRACK = 2'd1
`ifdef TLM_FAULT_LATCH_EN
    ,S_FAULT = 2'd2
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [5:0]         lamp_q, lamp_d;
  logic               samp_vld_q, samp_vld_d;
  logic [1:0]         phase_q, phase_d;
  logic               pv_q, pv_d;
  logic               pat_q, pat_d;
  logic               seq_q, seq_d;
  logic               dur_q, dur_d;
  logic [2:0]         flags_q, flags_d;
  logic [7:0]         rot_q, rot_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               first_q, first_d;

  logic               legal;
  logic [1:0]         code;
  logic               in_fault;
  logic               chg;
  logic [DWELL_W-1:0] req_dwell;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_SYNC;
      lamp_q     <= '0;
      samp_vld_q <= 1'b0;
      phase_q    <= 2'b00;
      pv_q       <= 1'b0;
      pat_q      <= 1'b0;
      seq_q      <= 1'b0;
      dur_q      <= 1'b0;
      flags_q    <= 3'b000;
      rot_q      <= 8'd0;
      dwell_q    <= '0;
      first_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      lamp_q     <= lamp_d;
      samp_vld_q <= samp_vld_d;
      phase_q    <= phase_d;
      pv_q       <= pv_d;
      pat_q      <= pat_d;
      seq_q      <= seq_d;
      dur_q      <= dur_d;
      flags_q    <= flags_d;
      rot_q      <= rot_d;
      dwell_q    <= dwell_d;
      first_q    <= first_d;
    end
  end

  // The sample register holds zeros straight out of reset; it is not a real observation.
  always_comb begin
    lamp_d     = {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g};
    samp_vld_d = 1'b1;
  end

  always_comb begin
    legal = 1'b1;
    code  = 2'b00;
    case (lamp_q)
      6'b001_100: code = 2'b00;
      6'b010_100: code = 2'b01;
      6'b100_001: code = 2'b10;
      6'b100_010: code = 2'b11;
      default:    legal = 1'b0;
    endcase
  end

  // FSM output process
  always_comb begin
`ifdef TLM_FAULT_LATCH_EN
    in_fault = (state_q == S_FAULT);
    fault    = in_fault;
`else
    in_fault = 1'b0;
`endif
  end

  always_comb begin
    chg       = (state_q == S_TRACK) && samp_vld_q && legal && (code != phase_q);
    req_dwell = phase_q[0] ? YELLOW_DW : GREEN_DW;
    pat_d     = samp_vld_q && !legal && !in_fault;
    seq_d     = chg && (code != phase_q + 2'd1);
    dur_d     = chg && !first_q && (dwell_q != req_dwell);
  end

  // FSM next-state process
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SYNC:  if (samp_vld_q && legal) state_d = S_TRACK;
      S_TRACK: if (samp_vld_q && !legal) state_d = S_SYNC;
      default: state_d = state_q;
    endcase
`ifdef TLM_FAULT_LATCH_EN
    if (pat_d || seq_d || dur_d) state_d = S_FAULT;
`endif
  end

  always_comb begin
    phase_d = phase_q;
    pv_d    = pv_q;
    dwell_d = dwell_q;
    first_d = first_q;
    rot_d   = rot_q;
    if (in_fault) begin
      pv_d = 1'b0;
    end else if (samp_vld_q) begin
      if (!legal) begin
        pv_d = 1'b0;
      end else if (state_q == S_SYNC) begin
        phase_d = code;
        pv_d    = 1'b1;
        dwell_d = DWELL_ONE;
        first_d = 1'b1;
      end else if (!chg) begin
        dwell_d = (dwell_q == '1) ? dwell_q : dwell_q + DWELL_ONE;
      end else begin
        phase_d = code;
        dwell_d = DWELL_ONE;
        first_d = 1'b0;
        if (!seq_d && code == 2'b00) rot_d = rot_q + 8'd1;
      end
    end
`ifdef TLM_FAULT_LATCH_EN
    if (state_d == S_FAULT) pv_d = 1'b0;
`endif
  end

  // A clear never hides a pulse that is visible during the clearing cycle.
  always_comb begin
    flags_d = (clr_err ? {dur_q, seq_q, pat_q} : flags_q) | {dur_d, seq_d, pat_d};
  end

  assign phase       = phase_q;
  assign phase_valid = pv_q;
  assign err_pat     = pat_q;
  assign err_seq     = seq_q;
  assign err_dur     = dur_q;
  assign err_flags   = flags_q;
  assign rotations   = rot_q;

endmodule

// File: tb/tb_tl_monitor.sv
// Bench for tl_monitor: directed segment table, hand corner cases, and randomized lamps against a reference model.
module tb_tl_monitor;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [5:0] lamps;
  logic       clr_err;
  logic [1:0] phase;
  logic       phase_valid, err_pat, err_seq, err_dur;
  logic [2:0] err_flags;
  logic [7:0] rotations;
`ifdef TLM_FAULT_LATCH_EN
  logic       fault;
`endif

  tl_monitor dut (
    .clk(clk), .rst_n(rst_n),
    .ns_r(lamps[5]), .ns_y(lamps[4]), .ns_g(lamps[3]),
    .ew_r(lamps[2]), .ew_y(lamps[1]), .ew_g(lamps[0]),
    .clr_err(clr_err), .phase(phase), .phase_valid(phase_valid),
    .err_pat(err_pat), .err_seq(err_seq), .err_dur(err_dur),
    .err_flags(err_flags),
`ifdef TLM_FAULT_LATCH_EN
    .fault(fault),
`endif
    .rotations(rotations)
  );

  localparam logic [5:0] P0 = 6'b001_100;
  localparam logic [5:0] P1 = 6'b010_100;
  localparam logic [5:0] P2 = 6'b100_001;
  localparam logic [5:0] P3 = 6'b100_010;
  localparam logic [5:0] BG = 6'b001_001;

  logic [5:0] legal_pat [4];
  int checks = 0;
  int errors = 0;
  bit use_model = 1'b1;
  int n_pat, n_seq, n_dur;

  // Reference model: behaviour of the monitor stated in terms of lamp history.
  logic [5:0] m_stage;
  bit         m_stage_vld, m_track, m_first, m_valid;
  bit         m_pat, m_seq, m_dur;
  bit [2:0]   m_flags;
  int         m_phase, m_dwell, m_rot;

  function automatic int find_code(logic [5:0] l);
    for (int i = 0; i < 4; i++) if (legal_pat[i] == l) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_stage = '0; m_stage_vld = 0; m_track = 0; m_first = 0; m_valid = 0;
    m_pat = 0; m_seq = 0; m_dur = 0; m_flags = 0; m_phase = 0; m_dwell = 0; m_rot = 0;
  endtask

  task automatic model_edge(logic [5:0] lam_in, bit clr);
    int c;
    bit p, s, d;
    bit [2:0] shown;
    shown = {m_dur, m_seq, m_pat};
    p = 0; s = 0; d = 0;
    if (m_stage_vld) begin
      c = find_code(m_stage);
      if (c < 0) begin
        p = 1; m_track = 0; m_valid = 0;
      end else if (!m_track) begin
        m_track = 1; m_phase = c; m_valid = 1; m_dwell = 1; m_first = 1;
      end else if (c == m_phase) begin
        m_dwell = (m_dwell >= 255) ? 255 : m_dwell + 1;
      end else begin
        s = (c != (m_phase + 1) % 4);
        d = !m_first && (m_dwell != ((m_phase % 2 == 0) ? 6 : 3));
        if (m_phase == 3 && c == 0) m_rot = (m_rot + 1) % 256;
        m_first = 0; m_dwell = 1; m_phase = c;
      end
    end
    m_flags = (clr ? shown : m_flags) | {d, s, p};
    m_pat = p; m_seq = s; m_dur = d;
    m_stage = lam_in; m_stage_vld = 1;
  endtask

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick(logic [5:0] lam, bit clr);
    lamps = lam;
    clr_err = clr;
    @(posedge clk);
    model_edge(lam, clr);
    @(negedge clk);
    n_pat += int'(err_pat); n_seq += int'(err_seq); n_dur += int'(err_dur);
    if (use_model)
      check("model", {16'd0, phase, phase_valid, err_pat, err_seq, err_dur, err_flags, rotations},
            {16'd0, m_phase[1:0], m_valid, m_pat, m_seq, m_dur, m_flags, m_rot[7:0]});
  endtask

  task automatic repeat_tick(logic [5:0] lam, int n, bit clr);
    for (int i = 0; i < n; i++) tick(lam, clr);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; lamps = '0; clr_err = 1'b0;
    model_reset();
    n_pat = 0; n_seq = 0; n_dur = 0;
    @(negedge clk);
    check("reset_outputs", {19'd0, phase, phase_valid, err_pat, err_seq, err_dur, err_flags, rotations}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [5:0] lam;
    int         n;
    bit         clr;
    bit [2:0]   flags;
    int         rot;
    bit         valid;
    int         npat, nseq, ndur;
  } seg_t;

  seg_t tbl [18];

  int cur, len, pick;
  logic [5:0] lam_r;

  initial begin
    legal_pat[0] = P0; legal_pat[1] = P1; legal_pat[2] = P2; legal_pat[3] = P3;
    rst_n = 1'b0; lamps = '0; clr_err = 1'b0;
    model_reset();
    @(negedge clk);

`ifdef TLM_FAULT_LATCH_EN
    use_model = 1'b0;
    do_reset();
    repeat_tick(P0, 6, 0); repeat_tick(P1, 3, 0); repeat_tick(P2, 7, 0); repeat_tick(P3, 3, 0);
    check("fault_set", {31'd0, fault}, 32'd1);
    check("fault_flags", {29'd0, err_flags}, 32'd4);
    for (int r = 0; r < 3; r++) begin
      repeat_tick(P0, 6, 0); repeat_tick(P1, 3, 0); repeat_tick(P2, 6, 0); repeat_tick(P3, 3, 0);
    end
    repeat_tick(P0, 3, 0);
    check("fault_rot_frozen", {24'd0, rotations}, 32'd0);
    check("fault_no_pulses", n_dur + n_seq + n_pat, 32'd1);
    check("fault_valid_low", {31'd0, phase_valid}, 32'd0);
    repeat_tick(P0, 2, 1);
    check("fault_clr_flags", {29'd0, err_flags}, 32'd0);
    check("fault_held", {31'd0, fault}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("fault_reset", {31'd0, fault}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
`else
    //           lam  n  clr flags   rot valid pat seq dur
    tbl[0]  = '{P0, 6, 0, 3'b000, 0, 1, 0, 0, 0};
    tbl[1]  = '{P1, 3, 0, 3'b000, 0, 1, 0, 0, 0};
    tbl[2]  = '{P2, 6, 0, 3'b000, 0, 1, 0, 0, 0};
    tbl[3]  = '{P3, 3, 0, 3'b000, 0, 1, 0, 0, 0};
    tbl[4]  = '{P0, 6, 0, 3'b000, 1, 1, 0, 0, 0};
    tbl[5]  = '{P1, 3, 0, 3'b000, 1, 1, 0, 0, 0};
    tbl[6]  = '{P2, 6, 0, 3'b000, 1, 1, 0, 0, 0};
    tbl[7]  = '{P3, 3, 0, 3'b000, 1, 1, 0, 0, 0};
    tbl[8]  = '{P0, 7, 0, 3'b000, 2, 1, 0, 0, 0};
    tbl[9]  = '{P1, 3, 0, 3'b100, 2, 1, 0, 0, 1};
    tbl[10] = '{P2, 6, 1, 3'b000, 2, 1, 0, 0, 1};
    tbl[11] = '{P0, 6, 0, 3'b010, 2, 1, 0, 1, 1};
    tbl[12] = '{P2, 6, 0, 3'b010, 2, 1, 0, 2, 1};
    tbl[13] = '{P3, 3, 0, 3'b010, 2, 1, 0, 2, 1};
    tbl[14] = '{P0, 6, 0, 3'b010, 3, 1, 0, 2, 1};
    tbl[15] = '{BG, 2, 0, 3'b011, 3, 0, 1, 2, 1};
    tbl[16] = '{P1, 2, 0, 3'b011, 3, 1, 2, 2, 1};
    tbl[17] = '{P2, 6, 0, 3'b011, 3, 1, 2, 2, 1};

    do_reset();
    for (int i = 0; i < 18; i++) begin
      repeat_tick(tbl[i].lam, tbl[i].n, tbl[i].clr);
      check($sformatf("seg%0d_flags", i), {29'd0, err_flags}, {29'd0, tbl[i].flags});
      check($sformatf("seg%0d_rot", i), {24'd0, rotations}, tbl[i].rot);
      check($sformatf("seg%0d_valid", i), {31'd0, phase_valid}, {31'd0, tbl[i].valid});
      check($sformatf("seg%0d_pulses", i), n_pat * 10000 + n_seq * 100 + n_dur,
            tbl[i].npat * 10000 + tbl[i].nseq * 100 + tbl[i].ndur);
    end

    // One-cycle first phase is exempt; later phases are checked.
    do_reset();
    tick(P3, 0);
    check("first_valid_c1", {31'd0, phase_valid}, 32'd0);
    tick(P0, 0);
    check("first_valid_c2", {31'd0, phase_valid}, 32'd1);
    repeat_tick(P0, 5, 0); repeat_tick(P1, 3, 0);
    check("first_exempt", n_dur, 32'd0);
    repeat_tick(P2, 5, 0); repeat_tick(P3, 3, 0);
    check("first_later_dur", n_dur, 32'd1);
    check("first_rot", {24'd0, rotations}, 32'd1);
    check("first_no_seq", n_seq, 32'd0);

    // clr_err coinciding with fresh err_pat pulses.
    do_reset();
    repeat_tick(P0, 6, 0);
    tick(BG, 0); tick(BG, 1); tick(BG, 1);
    check("clr_pat_pulse", {31'd0, err_pat}, 32'd1);
    check("clr_pat_flag", {31'd0, err_flags[0]}, 32'd1);
    tick(P1, 0); tick(P1, 1); tick(P1, 1);
    check("clr_done", {29'd0, err_flags}, 32'd0);

    // Stuck phase: 262 cycles would alias to 6 on wrap; saturation must report it.
    do_reset();
    tick(P3, 0);
    repeat_tick(P0, 262, 0);
    repeat_tick(P1, 3, 0);
    check("sat_dur", n_dur, 32'd1);
    check("sat_rot", {24'd0, rotations}, 32'd1);

    // Asynchronous reset mid-phase.
    lamps = P1;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {19'd0, phase, phase_valid, err_pat, err_seq, err_dur, err_flags, rotations}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    n_pat = 0; n_seq = 0; n_dur = 0;

    // Randomized traffic, mostly legal with occasional faults.
    cur = 0;
    for (int k = 0; k < 300; k++) begin
      pick = $urandom_range(0, 99);
      if (pick < 6) begin
        lam_r = 6'($urandom);
        repeat_tick(lam_r, $urandom_range(1, 3), $urandom_range(0, 19) == 0);
      end else begin
        if (pick < 14) cur = $urandom_range(0, 3);
        else cur = (cur + 1) % 4;
        len = ((cur % 2 == 0) ? 6 : 3) + $urandom_range(0, 4) - 2;
        if (len < 1) len = 1;
        for (int j = 0; j < len; j++) tick(legal_pat[cur], $urandom_range(0, 19) == 0);
      end
    end
    repeat_tick(P0, 3, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
